// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, 2-entry skid buffer and synchronous flush.
// Define PIPE_TRACE_EN to add instr_in/instr_out tracing and a saturating stall_cnt.
module pipe_stage_skid #(
    parameter int                DATA_W      = 197,
    parameter int                CTRL_W      = 6,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_TRACE_EN
    ,
    input  logic [31:0]       instr_in,
    output logic [31:0]       instr_out,
    output logic [15:0]       stall_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } occ_t;

    logic              m_valid_q, m_valid_d;
    logic              s_valid_q, s_valid_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [DATA_W-1:0] s_data_q, s_data_d;
    logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
    logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
`ifdef PIPE_TRACE_EN
    logic [31:0]       m_instr_q, m_instr_d;
    logic [31:0]       s_instr_q, s_instr_d;
    logic [15:0]       stall_cnt_q, stall_cnt_d;
`endif

    logic accept;
    logic drain;
    occ_t occ;

    assign in_ready  = !s_valid_q;
    assign out_valid = m_valid_q;
    assign out_data  = m_data_q;
    // A bubble must never carry live control bits downstream.
    assign out_ctrl  = m_valid_q ? m_ctrl_q : BUBBLE_CTRL;
`ifdef PIPE_TRACE_EN
    assign instr_out = m_instr_q;
    assign stall_cnt = stall_cnt_q;
`endif

    assign accept = in_valid & !s_valid_q;
    assign drain  = m_valid_q & out_ready;
    assign occ    = occ_t'({m_valid_q, s_valid_q});

    always_comb begin
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        m_data_d  = m_data_q;
        s_data_d  = s_data_q;
        m_ctrl_d  = m_ctrl_q;
        s_ctrl_d  = s_ctrl_q;
`ifdef PIPE_TRACE_EN
        m_instr_d = m_instr_q;
        s_instr_d = s_instr_q;
`endif
        case (occ)
            EMPTY: begin
                if (accept) begin
                    m_valid_d = 1'b1;
                    m_data_d  = in_data;
                    m_ctrl_d  = in_ctrl;
`ifdef PIPE_TRACE_EN
                    m_instr_d = instr_in;
`endif
                end
            end
            ONE: begin
                if (accept && drain) begin
                    m_data_d  = in_data;
                    m_ctrl_d  = in_ctrl;
`ifdef PIPE_TRACE_EN
                    m_instr_d = instr_in;
`endif
                end else if (accept) begin
                    s_valid_d = 1'b1;
                    s_data_d  = in_data;
                    s_ctrl_d  = in_ctrl;
`ifdef PIPE_TRACE_EN
                    s_instr_d = instr_in;
`endif
                end else if (drain) begin
                    m_valid_d = 1'b0;
                end
            end
            FULL: begin
                if (drain) begin
                    s_valid_d = 1'b0;
                    m_data_d  = s_data_q;
                    m_ctrl_d  = s_ctrl_q;
`ifdef PIPE_TRACE_EN
                    m_instr_d = s_instr_q;
`endif
                end
            end
            default: begin
                m_valid_d = 1'b0;
                s_valid_d = 1'b0;
            end
        endcase
        // Flush only kills the valid bits; payload registers keep stale contents.
        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end
    end

`ifdef PIPE_TRACE_EN
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (m_valid_q && !out_ready && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_valid_q   <= 1'b0;
            s_valid_q   <= 1'b0;
            m_data_q    <= '0;
            s_data_q    <= '0;
            m_ctrl_q    <= '0;
            s_ctrl_q    <= '0;
`ifdef PIPE_TRACE_EN
            m_instr_q   <= '0;
            s_instr_q   <= '0;
            stall_cnt_q <= '0;
`endif
        end else begin
            m_valid_q   <= m_valid_d;
            s_valid_q   <= s_valid_d;
            m_data_q    <= m_data_d;
            s_data_q    <= s_data_d;
            m_ctrl_q    <= m_ctrl_d;
            s_ctrl_q    <= s_ctrl_d;
`ifdef PIPE_TRACE_EN
            m_instr_q   <= m_instr_d;
            s_instr_q   <= s_instr_d;
            stall_cnt_q <= stall_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: vector table, scoreboard-checked random traffic,
// reset/flush corner sequences, and PIPE_TRACE_EN checks when that macro is defined.
module tb_pipe_stage_skid;

    localparam int DATA_W = 197;
    localparam int CTRL_W = 6;
    localparam logic [CTRL_W-1:0] ALT_BUBBLE = 6'b000001;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic              in_ready2;
    logic              out_valid2;
    logic [DATA_W-1:0] out_data2;
    logic [CTRL_W-1:0] out_ctrl2;
`ifdef PIPE_TRACE_EN
    logic [31:0]       instr_in;
    logic [31:0]       instr_out;
    logic [15:0]       stall_cnt;
    logic [31:0]       instr_out2;
    logic [15:0]       stall_cnt2;
`endif

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [CTRL_W-1:0] ctrl;
`ifdef PIPE_TRACE_EN
        logic [31:0]       instr;
`endif
    } entry_t;

    typedef struct {
        logic              v;
        logic [DATA_W-1:0] d;
        logic [CTRL_W-1:0] c;
        logic              r;
        logic              f;
        logic              exp_ov;
        logic              exp_ir;
    } vec_t;

    entry_t sb[$];
    vec_t   tbl[17];

    pipe_stage_skid dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl)
`ifdef PIPE_TRACE_EN
        ,
        .instr_in  (instr_in),
        .instr_out (instr_out),
        .stall_cnt (stall_cnt)
`endif
    );

    pipe_stage_skid #(.BUBBLE_CTRL(ALT_BUBBLE)) dut2 (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready2),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid2),
        .out_ready (out_ready),
        .out_data  (out_data2),
        .out_ctrl  (out_ctrl2)
`ifdef PIPE_TRACE_EN
        ,
        .instr_in  (instr_in),
        .instr_out (instr_out2),
        .stall_cnt (stall_cnt2)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input int d, input logic [CTRL_W-1:0] c,
                                input logic r, input logic f, input logic ov, input logic ir);
        vec_t t;
        t.v = v; t.d = DATA_W'(d); t.c = c; t.r = r; t.f = f; t.exp_ov = ov; t.exp_ir = ir;
        return t;
    endfunction

    // Evaluate the handshake at the negedge, update the scoreboard, then step past the posedge.
    task automatic cycle();
        entry_t e;
        logic acc, drn;
        @(negedge clock);
        acc = in_valid && in_ready;
        drn = out_valid && out_ready;
        if (!out_valid) begin
            check("bubble_ctrl", 256'(out_ctrl), 256'(6'b0));
            check("bubble_ctrl_alt", 256'(out_ctrl2), 256'(ALT_BUBBLE));
        end
        if (drn) begin
            if (sb.size() == 0) begin
                check("unexpected_out", 256'(out_data), 256'hDEAD);
            end else begin
                e = sb.pop_front();
                check("out_data", 256'(out_data), 256'(e.data));
                check("out_ctrl", 256'(out_ctrl), 256'(e.ctrl));
`ifdef PIPE_TRACE_EN
                check("instr_out", 256'(instr_out), 256'(e.instr));
`endif
            end
        end
        if (acc && !flush) begin
            e.data = in_data;
            e.ctrl = in_ctrl;
`ifdef PIPE_TRACE_EN
            e.instr = instr_in;
`endif
            sb.push_back(e);
        end
        if (flush) sb.delete();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                                 input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = r;
        flush     = f;
`ifdef PIPE_TRACE_EN
        instr_in  = d[31:0] ^ 32'hA5A5_0F0F;
`endif
    endtask

    task automatic checkOutput(input string name, input logic ov, input logic ir);
        check({name, "_out_valid"}, 256'(out_valid), 256'(ov));
        check({name, "_in_ready"}, 256'(in_ready), 256'(ir));
    endtask

    initial begin
        logic [DATA_W-1:0] rd;

        tbl[0]  = mk(1, 1,  6'b001100, 1, 0, 0, 1);
        tbl[1]  = mk(1, 2,  6'b001100, 1, 0, 1, 1);
        tbl[2]  = mk(1, 3,  6'b001100, 1, 0, 1, 1);
        tbl[3]  = mk(0, 0,  6'b000000, 1, 0, 1, 1);
        tbl[4]  = mk(1, 10, 6'b010010, 0, 0, 0, 1);
        tbl[5]  = mk(1, 11, 6'b100001, 0, 0, 1, 1);
        tbl[6]  = mk(1, 12, 6'b000110, 0, 0, 1, 0);
        tbl[7]  = mk(1, 12, 6'b000110, 1, 0, 1, 0);
        tbl[8]  = mk(1, 12, 6'b000110, 1, 0, 1, 1);
        tbl[9]  = mk(0, 0,  6'b000000, 1, 0, 1, 1);
        tbl[10] = mk(1, 13, 6'b111111, 0, 0, 0, 1);
        tbl[11] = mk(1, 14, 6'b011110, 0, 0, 1, 1);
        tbl[12] = mk(1, 20, 6'b001000, 0, 1, 1, 0);
        tbl[13] = mk(0, 0,  6'b000000, 1, 0, 0, 1);
        tbl[14] = mk(1, 21, 6'b110011, 1, 0, 0, 1);
        tbl[15] = mk(1, 22, 6'b101010, 1, 1, 1, 1);
        tbl[16] = mk(0, 0,  6'b000000, 1, 0, 0, 1);

        // Inputs presented while reset is held must be discarded.
        reset_n = 1'b0;
        applyStimulus(1, 99, 6'h3F, 1, 0);
        repeat (3) @(posedge clock);
        #1;
        checkOutput("in_reset", 0, 1);
        check("in_reset_ctrl", 256'(out_ctrl), 256'(6'b0));
        check("in_reset_ctrl_alt", 256'(out_ctrl2), 256'(ALT_BUBBLE));
        check("in_reset_data", 256'(out_data), 256'(0));
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        checkOutput("post_reset", 0, 1);
        applyStimulus(0, 0, 0, 1, 0);
        @(posedge clock);
        #1;
        checkOutput("post_reset_edge", 0, 1);

        for (int i = 0; i < 17; i++) begin
            applyStimulus(tbl[i].v, tbl[i].d, tbl[i].c, tbl[i].r, tbl[i].f);
            checkOutput($sformatf("vec%0d", i), tbl[i].exp_ov, tbl[i].exp_ir);
            cycle();
        end
        check("table_sb_empty", 256'(sb.size()), 256'(0));

        for (int i = 0; i < 400; i++) begin
            rd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            applyStimulus($urandom_range(0, 3) != 0, rd, CTRL_W'($urandom),
                          $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
            cycle();
        end
        applyStimulus(0, 0, 0, 1, 0);
        repeat (4) cycle();
        check("random_sb_empty", 256'(sb.size()), 256'(0));
        checkOutput("random_drained", 0, 1);

        // Reset dropped between edges must clear outputs without waiting for a clock.
        applyStimulus(1, 40, 6'b010101, 0, 0);
        cycle();
        checkOutput("one_state", 1, 1);
        applyStimulus(0, 0, 0, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset", 0, 1);
        check("async_reset_ctrl", 256'(out_ctrl), 256'(6'b0));
        check("async_reset_data", 256'(out_data), 256'(0));
        sb.delete();
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("after_async", 0, 1);

`ifdef PIPE_TRACE_EN
        check("stall_cnt_reset", 256'(stall_cnt), 256'(0));
        applyStimulus(1, 30, 6'b001100, 0, 0);
        instr_in = 32'h8B02_0020;
        cycle();
        applyStimulus(0, 0, 0, 0, 0);
        repeat (3) cycle();
        check("trace_instr", 256'(instr_out), 256'(32'h8B02_0020));
        check("trace_data", 256'(out_data), 256'(30));
        check("stall_cnt_3", 256'(stall_cnt), 256'(16'd3));
        applyStimulus(0, 0, 0, 0, 1);
        cycle();
        check("stall_after_flush", 256'(stall_cnt), 256'(16'd4));
        applyStimulus(0, 0, 0, 1, 0);
        cycle();
        check("stall_cnt_hold", 256'(stall_cnt), 256'(16'd4));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
